// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding, default widths and clog2 helper for demux_seq
package demux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int DEF_N_OUT       = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_seq_if.sv
// rtl/demux_seq_if.sv - producer-side and channel-side handshake bundle of demux_seq
interface demux_seq_if
  import demux_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int DATA_W = DEF_DATA_W,
  localparam int SEL_W = clog2(N_OUT)
);

  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  in_sel;
  logic [DATA_W-1:0] in_data;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_seq_onehot_decode.sv
// rtl/demux_seq_onehot_decode.sv - select to one-hot decoder with an in-range flag for non-power-of-two N_OUT
module onehot_decode #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot,
  output logic             in_range
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_OUT);

  assign in_range = ({1'b0, sel} < N_LIM);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/demux_seq.sv
// rtl/demux_seq.sv - registered 1-to-N_OUT demux, addressed or scan routing; DEMUX_TIMEOUT_EN adds a HOLD timeout
module demux_seq
  import demux_pkg::*;
#(
  parameter int N_OUT       = DEF_N_OUT,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int SEL_W      = clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  demux_seq_if.slave       bus,
  output logic [SEL_W-1:0] cur_sel,
  output logic             sel_err,
  output logic             timeout
);

  logic [0:0]       state;
  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] hold_sel;
  logic [SEL_W-1:0] tgt;
  logic [N_OUT-1:0] tgt_oh;
  logic             tgt_ok;
  logic             deliver;
  logic             accept;
  logic             load;
  logic             expire;

  // out_valid is one-hot on hold_sel, so this equals out_ready[hold_sel] while holding
  assign deliver      = (state == ST_HOLD) && (|(bus.out_valid & bus.out_ready));
  assign bus.in_ready = (state == ST_IDLE) || deliver;
  assign accept       = bus.in_valid && bus.in_ready;
  assign tgt          = mode ? scan_ptr : bus.in_sel;
  assign load         = accept && tgt_ok;
  assign cur_sel      = (state == ST_HOLD) ? hold_sel : scan_ptr;

  onehot_decode #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_tgt_dec (
    .sel      (tgt),
    .onehot   (tgt_oh),
    .in_range (tgt_ok)
  );

`ifdef DEMUX_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] hold_cnt;

  assign expire = (state == ST_HOLD) && !deliver && (hold_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if ((state != ST_HOLD) || deliver || expire) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  // constant 0; the comparison only keeps TIMEOUT_CYC referenced in the counter-less build
  assign expire = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.out_valid <= '0;
      bus.out_data  <= '0;
      scan_ptr      <= '0;
      hold_sel      <= '0;
      sel_err       <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      sel_err <= accept && !tgt_ok;
      timeout <= expire;
      if (accept && mode) begin
        scan_ptr <= (scan_ptr == SEL_W'(N_OUT - 1)) ? '0 : scan_ptr + 1'b1;
      end
      if (load) begin
        state         <= ST_HOLD;
        bus.out_valid <= tgt_oh;
        bus.out_data  <= bus.in_data;
        hold_sel      <= tgt;
      end else if (deliver || expire) begin
        state         <= ST_IDLE;
        bus.out_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_demux_seq.sv
// tb/tb_demux_seq.sv - self-checking bench for demux_seq on N_OUT = 8, 5 and 6 instances
module tb_demux_seq;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         dut;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] data;
    int         exp_ch;
    bit         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tmode = 1'b0;
  logic       tv = 1'b0;
  logic [2:0] tsel = '0;
  logic [7:0] tdata = '0;
  logic [7:0] trdy = 8'hFF;
  int         sel_dut = 0;

  int   vecs = 0;
  int   errs = 0;
  int   stalls = 0;
  bit   sb_on = 1'b0;
  bit   serr_pend = 1'b0;
  exp_t q[$];
  vec_t tab[16];

  logic [2:0] cur8, cur5, cur6;
  logic       serr8, serr5, serr6;
  logic       tmo8, tmo5, tmo6;

  logic [7:0] o_valid;
  logic [7:0] o_data;
  logic       o_inrdy;
  logic [2:0] o_cur;
  logic       o_serr;
  logic       o_tmo;

  always #5 clk = ~clk;

  demux_seq_if #(.N_OUT(8), .DATA_W(8)) if8 ();
  demux_seq_if #(.N_OUT(5), .DATA_W(8)) if5 ();
  demux_seq_if #(.N_OUT(6), .DATA_W(8)) if6 ();

  assign if8.in_valid  = tv && (sel_dut == 0);
  assign if8.in_sel    = tsel;
  assign if8.in_data   = tdata;
  assign if8.out_ready = trdy;
  assign if5.in_valid  = tv && (sel_dut == 1);
  assign if5.in_sel    = tsel;
  assign if5.in_data   = tdata;
  assign if5.out_ready = trdy[4:0];
  assign if6.in_valid  = tv && (sel_dut == 2);
  assign if6.in_sel    = tsel;
  assign if6.in_data   = tdata;
  assign if6.out_ready = trdy[5:0];

  demux_seq #(.N_OUT(8), .DATA_W(8), .TIMEOUT_CYC(4)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .mode (tmode), .bus (if8.slave),
    .cur_sel (cur8), .sel_err (serr8), .timeout (tmo8)
  );
  demux_seq #(.N_OUT(5), .DATA_W(8), .TIMEOUT_CYC(4)) u_dut5 (
    .clk (clk), .rst_n (rst_n), .mode (tmode), .bus (if5.slave),
    .cur_sel (cur5), .sel_err (serr5), .timeout (tmo5)
  );
  demux_seq #(.N_OUT(6), .DATA_W(8), .TIMEOUT_CYC(4)) u_dut6 (
    .clk (clk), .rst_n (rst_n), .mode (tmode), .bus (if6.slave),
    .cur_sel (cur6), .sel_err (serr6), .timeout (tmo6)
  );

  always_comb begin
    o_valid = if8.out_valid;
    o_data  = if8.out_data;
    o_inrdy = if8.in_ready;
    o_cur   = cur8;
    o_serr  = serr8;
    o_tmo   = tmo8;
    if (sel_dut == 1) begin
      o_valid = {3'b000, if5.out_valid};
      o_data  = if5.out_data;
      o_inrdy = if5.in_ready;
      o_cur   = cur5;
      o_serr  = serr5;
      o_tmo   = tmo5;
    end else if (sel_dut == 2) begin
      o_valid = {2'b00, if6.out_valid};
      o_data  = if6.out_data;
      o_inrdy = if6.in_ready;
      o_cur   = cur6;
      o_serr  = serr6;
      o_tmo   = tmo6;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every delivery handshake pops the oldest expected {channel, data}
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb_on && rst_n) begin
      if ((o_valid & trdy) != 8'h00) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_delivery: out_valid=%0h out_data=%0h, expected none", o_valid, o_data);
        end else begin
          e = q.pop_front();
          chk("deliver_valid", {24'h0, o_valid}, 32'(1) << e.ch);
          chk("deliver_data", {24'h0, o_data}, {24'h0, e.data});
        end
      end
      chk("sel_err", {31'h0, o_serr}, {31'h0, serr_pend});
      serr_pend = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic m, input logic [2:0] s, input logic [7:0] d, input int ch, input bit err);
    int   n;
    exp_t e;
    tmode = m;
    tsel  = s;
    tdata = d;
    tv    = 1'b1;
    if (!err) begin
      e.ch   = ch;
      e.data = d;
      q.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!o_inrdy && n < 40) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    if (!o_inrdy) begin
      vecs++;
      errs++;
      $display("FAIL accept_wait: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    tv        = 1'b0;
    serr_pend = err;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      tick(1);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic push_exp(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // N_OUT=5 scan wrap at full rate; in_sel=7 is ignored in scan mode
    tab[0]  = '{1, 1'b1, 3'd7, 8'h50, 0, 1'b0};
    tab[1]  = '{1, 1'b1, 3'd7, 8'h51, 1, 1'b0};
    tab[2]  = '{1, 1'b1, 3'd0, 8'h52, 2, 1'b0};
    tab[3]  = '{1, 1'b1, 3'd0, 8'h53, 3, 1'b0};
    tab[4]  = '{1, 1'b1, 3'd5, 8'h54, 4, 1'b0};
    tab[5]  = '{1, 1'b1, 3'd5, 8'h55, 0, 1'b0};
    tab[6]  = '{1, 1'b1, 3'd1, 8'h56, 1, 1'b0};
    // N_OUT=6 addressed with out-of-range selects, then scan/addressed interleave
    tab[7]  = '{2, 1'b0, 3'd7, 8'hE7, 0, 1'b1};
    tab[8]  = '{2, 1'b0, 3'd2, 8'h22, 2, 1'b0};
    tab[9]  = '{2, 1'b0, 3'd6, 8'hE6, 0, 1'b1};
    tab[10] = '{2, 1'b0, 3'd5, 8'h65, 5, 1'b0};
    tab[11] = '{2, 1'b0, 3'd0, 8'h60, 0, 1'b0};
    tab[12] = '{2, 1'b1, 3'd3, 8'h70, 0, 1'b0};
    tab[13] = '{2, 1'b1, 3'd3, 8'h71, 1, 1'b0};
    tab[14] = '{2, 1'b0, 3'd1, 8'h31, 1, 1'b0};
    tab[15] = '{2, 1'b1, 3'd0, 8'h72, 2, 1'b0};

    #12;
    chk("reset_valid", {24'h0, o_valid}, 32'h0);
    chk("reset_data", {24'h0, o_data}, 32'h0);
    chk("reset_cur_sel", {29'h0, o_cur}, 32'h0);
    chk("reset_in_ready", {31'h0, o_inrdy}, 32'h1);
    chk("reset_sel_err", {31'h0, o_serr}, 32'h0);
    chk("reset_timeout", {31'h0, o_tmo}, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick(1);
    sb_on = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tab[i].dut != sel_dut) begin
        drain();
        sel_dut = tab[i].dut;
      end
      send(tab[i].mode, tab[i].sel, tab[i].data, tab[i].exp_ch, tab[i].exp_err);
    end
    drain();
    chk("no_bubble_stalls", stalls, 0);

    // N_OUT=8 addressed delivery under backpressure; other channels ready
    sel_dut = 0;
    trdy = 8'hF7;
    send(1'b0, 3'd3, 8'hA5, 3, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", {24'h0, o_valid}, 32'h08);
      chk("bp_data", {24'h0, o_data}, 32'hA5);
      chk("bp_in_ready", {31'h0, o_inrdy}, 32'h0);
      chk("bp_cur_sel", {29'h0, o_cur}, 32'h3);
    end
    tick(1);
    trdy = 8'h08;
    @(negedge clk);
    chk("bp_release_in_ready", {31'h0, o_inrdy}, 32'h1);
    tick(1);
    trdy = 8'hFF;
    @(negedge clk);
    chk("bp_idle_valid", {24'h0, o_valid}, 32'h0);
    tick(1);

    // advance the scan pointer so the reset test can see it cleared
    send(1'b1, 3'd0, 8'h80, 0, 1'b0);
    send(1'b1, 3'd0, 8'h81, 1, 1'b0);
    drain();

    // delivery and accept in the same cycle: ch1 -> ch4 with no idle cycle
    trdy = 8'h00;
    send(1'b0, 3'd1, 8'h11, 1, 1'b0);
    tmode = 1'b0;
    tsel  = 3'd4;
    tdata = 8'h44;
    tv    = 1'b1;
    trdy  = 8'h02;
    push_exp(4, 8'h44);
    @(negedge clk);
    chk("reload_in_ready", {31'h0, o_inrdy}, 32'h1);
    tick(1);
    tv   = 1'b0;
    trdy = 8'h00;
    @(negedge clk);
    chk("reload_valid", {24'h0, o_valid}, 32'h10);
    chk("reload_data", {24'h0, o_data}, 32'h44);
    chk("reload_cur_sel", {29'h0, o_cur}, 32'h4);
    tick(1);
    trdy = 8'hFF;
    drain();

    // asynchronous reset while holding at channel 5
    trdy = 8'h00;
    send(1'b0, 3'd5, 8'h5A, 5, 1'b0);
    @(negedge clk);
    chk("hold_cur_sel", {29'h0, o_cur}, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {24'h0, o_valid}, 32'h0);
    chk("async_rst_data", {24'h0, o_data}, 32'h0);
    chk("async_rst_cur_sel", {29'h0, o_cur}, 32'h0);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick(1);
    trdy = 8'hFF;
    send(1'b1, 3'd6, 8'h77, 0, 1'b0);
    drain();

`ifdef DEMUX_TIMEOUT_EN
    // TIMEOUT_CYC=4: word dropped after 4 held cycles, then delivery on the 4th cycle wins
    trdy  = 8'h00;
    tmode = 1'b0;
    tsel  = 3'd2;
    tdata = 8'hC3;
    tv    = 1'b1;
    tick(1);
    tv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("to_hold_valid", {24'h0, o_valid}, 32'h04);
      chk("to_hold_pulse", {31'h0, o_tmo}, 32'h0);
    end
    @(negedge clk);
    chk("to_drop_valid", {24'h0, o_valid}, 32'h0);
    chk("to_pulse", {31'h0, o_tmo}, 32'h1);
    @(negedge clk);
    chk("to_pulse_end", {31'h0, o_tmo}, 32'h0);
    tick(1);
    tsel  = 3'd2;
    tdata = 8'hD4;
    tv    = 1'b1;
    push_exp(2, 8'hD4);
    tick(1);
    tv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("to_retry_valid", {24'h0, o_valid}, 32'h04);
    end
    tick(1);
    trdy = 8'h04;
    @(negedge clk);
    chk("to_retry_no_pulse", {31'h0, o_tmo}, 32'h0);
    tick(1);
    trdy = 8'hFF;
    @(negedge clk);
    chk("to_retry_no_pulse_after", {31'h0, o_tmo}, 32'h0);
    chk("to_retry_idle", {24'h0, o_valid}, 32'h0);
    tick(1);
`else
    // without the timeout the held word persists indefinitely
    trdy = 8'h00;
    send(1'b0, 3'd2, 8'hC3, 2, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("hold_forever_valid", {24'h0, o_valid}, 32'h04);
      chk("hold_forever_timeout", {31'h0, o_tmo}, 32'h0);
    end
    tick(1);
    trdy = 8'hFF;
`endif
    drain();

    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
